// File: rtl/aplic_pkg.sv
// rtl/aplic_pkg.sv - shared constants and types for the APLIC interrupt delivery control
package aplic_pkg;

  // IDC register byte offsets
  localparam logic [4:0] OFF_IDELIVERY  = 5'h00;
  localparam logic [4:0] OFF_IFORCE     = 5'h04;
  localparam logic [4:0] OFF_ITHRESHOLD = 5'h08;
  localparam logic [4:0] OFF_TOPI       = 5'h18;
  localparam logic [4:0] OFF_CLAIMI     = 5'h1C;

  // topi/claimi field positions: identity [25:16], priority [7:0]
  localparam int TOPI_ID_LSB   = 16;
  localparam int TOPI_PRIO_LSB = 0;

  // cycles spent after a claim ack so the tree and snapshot see the cleared bit
  localparam int SETTLE_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CLAIM_WAIT = 2'd1,
    SETTLE     = 2'd2
  } idc_state_e;

endpackage

// File: rtl/aplic_idc_eligible.sv
// rtl/aplic_idc_eligible.sv - threshold compare and topi formatting for one candidate
module aplic_idc_eligible
  import aplic_pkg::*;
#(
  parameter int intrNumW  = 10,
  parameter int intrPrioW = 8
) (
  input  logic                 valid_i,
  input  logic [intrNumW-1:0]  identity_i,
  input  logic [intrPrioW-1:0] prio_i,
  input  logic [intrPrioW-1:0] threshold_i,
  output logic                 eligible_o,
  output logic [31:0]          topi_o
);

  // A zero threshold disables masking; otherwise the candidate must be strictly more urgent
  always_comb begin
    eligible_o = valid_i && (identity_i != '0) &&
                 ((threshold_i == '0) || (prio_i < threshold_i));
    topi_o = '0;
    if (eligible_o) begin
      topi_o[TOPI_ID_LSB +: intrNumW]    = identity_i;
      topi_o[TOPI_PRIO_LSB +: intrPrioW] = prio_i;
    end
  end

endmodule

// File: rtl/aplic_idc_claim.sv
// rtl/aplic_idc_claim.sv - direct-mode IDC registers, hart interrupt line and claim handshake
module aplic_idc_claim
  import aplic_pkg::*;
#(
  parameter int intrNumW  = 10,
  parameter int intrPrioW = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 top_valid,
  input  logic [intrNumW-1:0]  top_identity,
  input  logic [intrPrioW-1:0] top_prio,
  input  logic                 reg_req,
  output logic                 reg_ready,
  input  logic                 reg_write,
  input  logic [4:0]           reg_offset,
  input  logic [31:0]          reg_wdata,
  output logic                 reg_rdValid,
  output logic [31:0]          reg_rdata,
  output logic                 claim_valid,
  output logic [intrNumW-1:0]  claim_identity,
  input  logic                 claim_ready,
  output logic                 hart_eip
);

  localparam logic [1:0] SETTLE_LAST = 2'(SETTLE_CYCLES - 1);

  idc_state_e           state_q, state_d;
  logic [1:0]           settle_cnt_q, settle_cnt_d;
  logic                 snap_valid_q;
  logic [intrNumW-1:0]  snap_identity_q;
  logic [intrPrioW-1:0] snap_prio_q;
  logic                 idelivery_q, idelivery_d;
  logic                 iforce_q, iforce_d;
  logic [intrPrioW-1:0] ithreshold_q, ithreshold_d;
  logic                 claim_valid_q, claim_valid_d;
  logic [intrNumW-1:0]  claim_identity_q, claim_identity_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [31:0]          rd_data_q, rd_data_d;
  logic                 hart_eip_q, hart_eip_d;
  logic                 eligible;
  logic [31:0]          topi;
  logic                 accept;
  logic                 unused_wdata;

  assign unused_wdata = ^reg_wdata;

  aplic_idc_eligible #(
    .intrNumW  (intrNumW),
    .intrPrioW (intrPrioW)
  ) u_eligible (
    .valid_i     (snap_valid_q),
    .identity_i  (snap_identity_q),
    .prio_i      (snap_prio_q),
    .threshold_i (ithreshold_q),
    .eligible_o  (eligible),
    .topi_o      (topi)
  );

  assign reg_ready      = (state_q == IDLE);
  assign accept         = reg_req && reg_ready;
  assign reg_rdValid    = rd_valid_q;
  assign reg_rdata      = rd_data_q;
  assign claim_valid    = claim_valid_q;
  assign claim_identity = claim_identity_q;
  assign hart_eip       = hart_eip_q;

  // Register decode, claim FSM next state and the interrupt line
  always_comb begin
    state_d          = state_q;
    settle_cnt_d     = settle_cnt_q;
    idelivery_d      = idelivery_q;
    iforce_d         = iforce_q;
    ithreshold_d     = ithreshold_q;
    claim_valid_d    = claim_valid_q;
    claim_identity_d = claim_identity_q;
    rd_valid_d       = 1'b0;
    rd_data_d        = rd_data_q;
    hart_eip_d       = idelivery_q && (eligible || iforce_q) && (state_q == IDLE);
    case (state_q)
      IDLE: begin
        if (accept && reg_write) begin
          case (reg_offset)
            OFF_IDELIVERY:  idelivery_d  = reg_wdata[0];
            OFF_IFORCE:     iforce_d     = reg_wdata[0];
            OFF_ITHRESHOLD: ithreshold_d = reg_wdata[intrPrioW-1:0];
            default: ;
          endcase
        end else if (accept) begin
          rd_valid_d = 1'b1;
          case (reg_offset)
            OFF_IDELIVERY:  rd_data_d = {31'b0, idelivery_q};
            OFF_IFORCE:     rd_data_d = {31'b0, iforce_q};
            OFF_ITHRESHOLD: rd_data_d = 32'(ithreshold_q);
            OFF_TOPI:       rd_data_d = topi;
            OFF_CLAIMI: begin
              if (eligible) begin
                rd_data_d        = topi;
                claim_valid_d    = 1'b1;
                claim_identity_d = snap_identity_q;
                state_d          = CLAIM_WAIT;
              end else begin
                // Claiming with nothing eligible consumes a forced interrupt
                rd_data_d = '0;
                iforce_d  = 1'b0;
              end
            end
            default:        rd_data_d = '0;
          endcase
        end
      end
      CLAIM_WAIT: begin
        if (claim_ready) begin
          claim_valid_d = 1'b0;
          settle_cnt_d  = '0;
          state_d       = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          state_d = IDLE;
        end else begin
          settle_cnt_d = settle_cnt_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, snapshot and register storage with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= IDLE;
      settle_cnt_q     <= '0;
      snap_valid_q     <= 1'b0;
      snap_identity_q  <= '0;
      snap_prio_q      <= '0;
      idelivery_q      <= 1'b0;
      iforce_q         <= 1'b0;
      ithreshold_q     <= '0;
      claim_valid_q    <= 1'b0;
      claim_identity_q <= '0;
      rd_valid_q       <= 1'b0;
      rd_data_q        <= '0;
      hart_eip_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      settle_cnt_q     <= settle_cnt_d;
      snap_valid_q     <= top_valid;
      snap_identity_q  <= top_identity;
      snap_prio_q      <= top_prio;
      idelivery_q      <= idelivery_d;
      iforce_q         <= iforce_d;
      ithreshold_q     <= ithreshold_d;
      claim_valid_q    <= claim_valid_d;
      claim_identity_q <= claim_identity_d;
      rd_valid_q       <= rd_valid_d;
      rd_data_q        <= rd_data_d;
      hart_eip_q       <= hart_eip_d;
    end
  end

endmodule
